// File: rtl/int_ctrl_multi_pkg.sv
// Shared types and constants for the multi-source interrupt controller.
package int_ctrl_multi_pkg;

  typedef enum logic [1:0] {
    ST_RST_SEQ = 2'd0,
    ST_IDLE    = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_e;

  localparam logic [15:0] VEC_NMI  = 16'hFFFA;
  localparam logic [15:0] VEC_RST  = 16'hFFFC;
  localparam logic [15:0] VEC_IDLE = 16'hFFFE;

  // Source k sits two bytes below source k-1; wrap below 0 is not a concern for k<=7.
  function automatic logic [15:0] irq_vector(input logic [15:0] top, input logic [2:0] k);
    return top - {12'd0, k, 1'b0};
  endfunction

endpackage

// File: rtl/int_ctrl_multi_if.sv
// Core <-> interrupt controller signal bundle. master = core/microcode side, slave = controller.
interface int_ctrl_multi_if #(
  parameter int NUM_IRQ = 4
);
  logic               ready;
  logic [NUM_IRQ-1:0] irq;
  logic               nmi;
  logic               hyp;
  logic [5:0]         trap_id;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               mc_sync;
  logic               i_flag;
  logic               i_clr_now;
  logic               hyper_rti;
  logic               intg;
  logic               nmig;
  logic               hyperg;
  logic               resp;
  logic               hyper_mode;
  logic               pc_hold;
  logic [7:0]         vector_hi;
  logic [7:0]         vector_lo;
  logic [2:0]         irq_src;
  logic [NUM_IRQ-1:0] irq_mask;

  modport master (
    output ready, irq, nmi, hyp, trap_id, mask_we, mask_wdata, mc_sync, i_flag, i_clr_now, hyper_rti,
    input  intg, nmig, hyperg, resp, hyper_mode, pc_hold, vector_hi, vector_lo, irq_src, irq_mask
  );

  modport slave (
    input  ready, irq, nmi, hyp, trap_id, mask_we, mask_wdata, mc_sync, i_flag, i_clr_now, hyper_rti,
    output intg, nmig, hyperg, resp, hyper_mode, pc_hold, vector_hi, vector_lo, irq_src, irq_mask
  );
endinterface

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module int_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [2:0]   idx
);

  // Scan from the top down so the lowest active index is the last one written.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/int_ctrl_multi.sv
// Arbitrates reset, hypervisor trap, NMI and masked level IRQs into a forced-BRK sequence
// taken at a microcode instruction boundary, and supplies the vector for that sequence.
//
//  state      | meaning
//  ST_RST_SEQ | reset sequence in flight, fetch vector FFFC, writes suppressed
//  ST_IDLE    | normal execution, looking for a take at each boundary
//  ST_SERVICE | injected BRK for a taken source; vector/source frozen
module int_ctrl_multi
  import int_ctrl_multi_pkg::*;
#(
  parameter int          NUM_IRQ     = 4,
  parameter logic [15:0] IRQ_VEC_TOP = 16'hFFFE,
  parameter logic [7:0]  HYP_VEC_HI  = 8'hFF
) (
  input logic              clk,
  input logic              reset,
  int_ctrl_multi_if.slave  bus
);

  int_state_e         state_q, state_d;
  logic               nmi_prev_q, hyp_prev_q;
  logic               nmi_pend_q, nmi_pend_d;
  logic               hyp_pend_q, hyp_pend_d;
  logic [5:0]         trap_q, trap_d;
  logic               hyper_mode_q, hyper_mode_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               nmig_q, nmig_d;
  logic               hyperg_q, hyperg_d;
  logic [2:0]         src_q, src_d;
  logic [15:0]        vec_q, vec_d;

  logic [NUM_IRQ-1:0] irq_req;
  logic               irq_valid;
  logic [2:0]         irq_idx;
  logic               boundary, take_hyp, take_nmi, take_irq;

  assign irq_req = bus.irq & mask_q;

  int_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req   (irq_req),
    .valid (irq_valid),
    .idx   (irq_idx)
  );

  // Next-state, take qualification and edge-latch update.
  always_comb begin
    state_d      = state_q;
    trap_d       = trap_q;
    hyper_mode_d = hyper_mode_q;
    mask_d       = mask_q;
    nmig_d       = nmig_q;
    hyperg_d     = hyperg_q;
    src_d        = src_q;
    vec_d        = vec_q;

    boundary = bus.mc_sync & bus.ready;
    take_hyp = (state_q == ST_IDLE) & boundary & hyp_pend_q;
    take_nmi = (state_q == ST_IDLE) & boundary & ~hyp_pend_q & nmi_pend_q & ~hyper_mode_q;
    // A pending NMI blocked by hyper mode also holds off IRQs, since hyper mode blocks both.
    take_irq = (state_q == ST_IDLE) & boundary & ~hyp_pend_q & ~nmi_pend_q & ~hyper_mode_q &
               irq_valid & ~bus.i_flag & ~bus.i_clr_now;

    // Edges are captured regardless of ready/state; a new edge on the take edge re-arms.
    nmi_pend_d = (nmi_pend_q & ~take_nmi) | (bus.nmi & ~nmi_prev_q);
    hyp_pend_d = (hyp_pend_q & ~take_hyp) | (bus.hyp & ~hyp_prev_q);
    if (bus.hyp & ~hyp_prev_q) trap_d = bus.trap_id;

    if (bus.ready) begin
      if (bus.mask_we)   mask_d       = bus.mask_wdata;
      if (bus.hyper_rti) hyper_mode_d = 1'b0;
      if (take_hyp)      hyper_mode_d = 1'b1;
    end

    case (state_q)
      ST_RST_SEQ, ST_SERVICE: begin
        if (boundary) begin
          state_d  = ST_IDLE;
          nmig_d   = 1'b0;
          hyperg_d = 1'b0;
          src_d    = '0;
        end
      end
      ST_IDLE: begin
        if (take_hyp) begin
          state_d  = ST_SERVICE;
          hyperg_d = 1'b1;
          nmig_d   = 1'b0;
          src_d    = '0;
          vec_d    = {HYP_VEC_HI, trap_q, 2'b00};
        end else if (take_nmi) begin
          state_d  = ST_SERVICE;
          nmig_d   = 1'b1;
          hyperg_d = 1'b0;
          src_d    = '0;
          vec_d    = VEC_NMI;
        end else if (take_irq) begin
          state_d  = ST_SERVICE;
          nmig_d   = 1'b0;
          hyperg_d = 1'b0;
          src_d    = irq_idx;
          vec_d    = irq_vector(IRQ_VEC_TOP, irq_idx);
        end
      end
      default: state_d = ST_RST_SEQ;
    endcase
  end

  // State register; edge-detect history follows the pins every cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_RST_SEQ;
      nmi_prev_q   <= 1'b0;
      hyp_prev_q   <= 1'b0;
      nmi_pend_q   <= 1'b0;
      hyp_pend_q   <= 1'b0;
      trap_q       <= '0;
      hyper_mode_q <= 1'b0;
      mask_q       <= '1;
      nmig_q       <= 1'b0;
      hyperg_q     <= 1'b0;
      src_q        <= '0;
      vec_q        <= VEC_RST;
    end else begin
      state_q      <= bus.ready ? state_d : state_q;
      nmi_prev_q   <= bus.nmi;
      hyp_prev_q   <= bus.hyp;
      nmi_pend_q   <= nmi_pend_d;
      hyp_pend_q   <= hyp_pend_d;
      trap_q       <= trap_d;
      hyper_mode_q <= hyper_mode_d;
      mask_q       <= mask_d;
      nmig_q       <= nmig_d;
      hyperg_q     <= hyperg_d;
      src_q        <= src_d;
      vec_q        <= vec_d;
    end
  end

  assign bus.intg       = (state_q != ST_IDLE);
  assign bus.pc_hold    = (state_q != ST_IDLE);
  assign bus.resp       = (state_q == ST_RST_SEQ);
  assign bus.nmig       = nmig_q;
  assign bus.hyperg     = hyperg_q;
  assign bus.hyper_mode = hyper_mode_q;
  assign bus.irq_src    = src_q;
  assign bus.irq_mask   = mask_q;
  assign bus.vector_hi  = (state_q == ST_IDLE) ? VEC_IDLE[15:8] : vec_q[15:8];
  assign bus.vector_lo  = (state_q == ST_IDLE) ? VEC_IDLE[7:0]  : vec_q[7:0];

endmodule

// File: tb/tb_int_ctrl_multi.sv
// Self-checking bench for int_ctrl_multi: IRQ vector table plus hand sequences for reset, NMI and hypervisor.
module tb_int_ctrl_multi;

  logic clk;
  logic reset;

  int_ctrl_multi_if #(.NUM_IRQ(4)) bus ();

  int_ctrl_multi #(
    .NUM_IRQ     (4),
    .IRQ_VEC_TOP (16'hFFFE),
    .HYP_VEC_HI  (8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [24:0] val;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic [3:0]  irq;
    logic [3:0]  mask;
    logic        i_flag;
    logic        clr;
    logic        take;
    logic [2:0]  src;
    logic [15:0] vec;
  } vec_t;
  vec_t tbl[9];

  // {intg, nmig, hyperg, resp, hyper_mode, pc_hold, vector, irq_src}
  function automatic logic [24:0] pk(input logic intg, input logic nmig, input logic hyperg,
                                     input logic resp, input logic hm, input logic [15:0] vec,
                                     input logic [2:0] src);
    return {intg, nmig, hyperg, resp, hm, intg, vec, src};
  endfunction

  function automatic logic [24:0] actual();
    return {bus.intg, bus.nmig, bus.hyperg, bus.resp, bus.hyper_mode, bus.pc_hold,
            bus.vector_hi, bus.vector_lo, bus.irq_src};
  endfunction

  localparam logic [24:0] E_RST    = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFC, 3'd0};
  localparam logic [24:0] E_IDLE   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFE, 3'd0};
  localparam logic [24:0] E_IDLE_H = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFE, 3'd0};
  localparam logic [24:0] E_NMI    = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFA, 3'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the expectation as the stimulus is applied, then pop it once the edge has produced output.
  task automatic step_exp(input string name, input logic [24:0] val);
    sb_t e;
    sb_t got;
    e.name = name;
    e.val  = val;
    sb_q.push_back(e);
    step();
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = sb_q.pop_front();
      check(got.name, {7'd0, actual()}, {7'd0, got.val});
    end
  endtask

  initial begin
    tbl[0] = '{"prio_1010",  4'b1010, 4'hF, 1'b0, 1'b0, 1'b1, 3'd1, 16'hFFFC};
    tbl[1] = '{"prio_1000",  4'b1000, 4'hF, 1'b0, 1'b0, 1'b1, 3'd3, 16'hFFF8};
    tbl[2] = '{"mask_off",   4'b0001, 4'hE, 1'b0, 1'b0, 1'b0, 3'd0, 16'hFFFE};
    tbl[3] = '{"iflag_set",  4'b0010, 4'hF, 1'b1, 1'b0, 1'b0, 3'd0, 16'hFFFE};
    tbl[4] = '{"clr_now",    4'b0010, 4'hF, 1'b0, 1'b1, 1'b0, 3'd0, 16'hFFFE};
    tbl[5] = '{"after_clr",  4'b0010, 4'hF, 1'b0, 1'b0, 1'b1, 3'd1, 16'hFFFC};
    tbl[6] = '{"src2",       4'b0100, 4'hF, 1'b0, 1'b0, 1'b1, 3'd2, 16'hFFFA};
    tbl[7] = '{"masked_lo",  4'b1111, 4'hC, 1'b0, 1'b0, 1'b1, 3'd2, 16'hFFFA};
    tbl[8] = '{"src0",       4'b0001, 4'hF, 1'b0, 1'b0, 1'b1, 3'd0, 16'hFFFE};

    reset          = 1'b0;
    bus.ready      = 1'b1;
    bus.irq        = '0;
    bus.nmi        = 1'b0;
    bus.hyp        = 1'b0;
    bus.trap_id    = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.mc_sync    = 1'b0;
    bus.i_flag     = 1'b0;
    bus.i_clr_now  = 1'b0;
    bus.hyper_rti  = 1'b0;

    // Reset for two clocks, then release and complete the reset sequence.
    step();
    step_exp("reset_state", E_RST);
    check("reset_mask", {28'd0, bus.irq_mask}, 32'hF);
    reset = 1'b1;
    step_exp("rst_seq_hold", E_RST);
    bus.mc_sync = 1'b1;
    step_exp("rst_to_idle", E_IDLE);
    bus.mc_sync = 1'b0;

    // IRQ vector table.
    for (int i = 0; i < 9; i++) begin
      bus.mask_we    = 1'b1;
      bus.mask_wdata = tbl[i].mask;
      step();
      bus.mask_we = 1'b0;
      check({tbl[i].name, "_mask"}, {28'd0, bus.irq_mask}, {28'd0, tbl[i].mask});
      bus.irq       = tbl[i].irq;
      bus.i_flag    = tbl[i].i_flag;
      bus.i_clr_now = tbl[i].clr;
      bus.mc_sync   = 1'b1;
      if (tbl[i].take) begin
        step_exp(tbl[i].name, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tbl[i].vec, tbl[i].src));
        bus.irq       = '0;
        bus.i_flag    = 1'b0;
        bus.i_clr_now = 1'b0;
        step_exp({tbl[i].name, "_done"}, E_IDLE);
      end else begin
        step_exp(tbl[i].name, E_IDLE);
      end
      bus.irq       = '0;
      bus.i_flag    = 1'b0;
      bus.i_clr_now = 1'b0;
      bus.mc_sync   = 1'b0;
    end

    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'hF;
    step();
    bus.mask_we = 1'b0;

    // NMI pulse while stalled is latched and taken once ready returns.
    bus.ready   = 1'b0;
    bus.mc_sync = 1'b1;
    bus.nmi     = 1'b1;
    step_exp("nmi_stall_a", E_IDLE);
    bus.nmi = 1'b0;
    step_exp("nmi_stall_b", E_IDLE);
    bus.ready = 1'b1;
    step_exp("nmi_take", E_NMI);
    step_exp("nmi_done", E_IDLE);
    bus.mc_sync = 1'b0;
    bus.nmi     = 1'b1;
    step_exp("nmi_edge2", E_IDLE);
    bus.mc_sync = 1'b1;
    step_exp("nmi_take2", E_NMI);
    bus.ready = 1'b0;
    step_exp("nmi_svc_hold", E_NMI);
    bus.ready = 1'b1;
    step_exp("nmi_done2", E_IDLE);
    step_exp("nmi_no_retake", E_IDLE);
    bus.nmi     = 1'b0;
    bus.mc_sync = 1'b0;

    // Hypervisor trap; NMI arriving in hyper mode waits for hyper_rti.
    bus.trap_id = 6'h05;
    bus.hyp     = 1'b1;
    step_exp("hyp_edge", E_IDLE);
    bus.hyp     = 1'b0;
    bus.mc_sync = 1'b1;
    step_exp("hyp_take", pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFF14, 3'd0));
    bus.nmi = 1'b1;
    step_exp("hyp_done", E_IDLE_H);
    bus.nmi = 1'b0;
    step_exp("nmi_deferred", E_IDLE_H);
    bus.mc_sync   = 1'b0;
    bus.hyper_rti = 1'b1;
    step_exp("hyper_rti", E_IDLE);
    bus.hyper_rti = 1'b0;
    bus.mc_sync   = 1'b1;
    step_exp("nmi_after_rti", E_NMI);
    step_exp("nmi_after_done", E_IDLE);
    bus.mc_sync = 1'b0;

    // hyp, nmi and irq0 all pending at the same boundary.
    bus.irq     = 4'b0001;
    bus.trap_id = 6'h02;
    bus.hyp     = 1'b1;
    bus.nmi     = 1'b1;
    step_exp("sim_edges", E_IDLE);
    bus.hyp     = 1'b0;
    bus.nmi     = 1'b0;
    bus.mc_sync = 1'b1;
    step_exp("sim_hyp", pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFF08, 3'd0));
    step_exp("sim_hyp_done", E_IDLE_H);
    step_exp("sim_blocked", E_IDLE_H);
    bus.mc_sync   = 1'b0;
    bus.hyper_rti = 1'b1;
    step_exp("sim_rti", E_IDLE);
    bus.hyper_rti = 1'b0;
    bus.mc_sync   = 1'b1;
    step_exp("sim_nmi", E_NMI);
    step_exp("sim_nmi_done", E_IDLE);
    step_exp("sim_irq0", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFE, 3'd0));
    bus.irq = '0;
    step_exp("sim_irq0_done", E_IDLE);
    bus.mc_sync = 1'b0;

    // Reset in the middle of a hypervisor sequence aborts it and clears hyper mode.
    bus.trap_id = 6'h3F;
    bus.hyp     = 1'b1;
    step_exp("abort_edge", E_IDLE);
    bus.hyp     = 1'b0;
    bus.mc_sync = 1'b1;
    step_exp("abort_take", pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFC, 3'd0));
    reset = 1'b0;
    step_exp("abort_reset", E_RST);
    reset = 1'b1;
    step_exp("abort_recover", E_IDLE);
    bus.mc_sync = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
